// File: rtl/wb_master_engine_pkg.sv
// Shared types and constants for the Wishbone classic-cycle master engine.
package wb_master_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_e;

    localparam int unsigned TMO_CNT_W = 16;

    // Packed command word: {we, adr, dat, sel}.
    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw + dw / 8;
    endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth, wrap-bit pointers, show-ahead read port.
module wb_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_master_engine.sv
// Queued command engine issuing one Wishbone classic cycle at a time, with
// ERR/timeout reporting and a held response until consumed.
module wb_master_engine
    import wb_master_engine_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned CMD_FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [WB_ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [WB_DATA_WIDTH-1:0]   cmd_dat,
    input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WB_DATA_WIDTH-1:0]   rsp_dat,
    output logic                       rsp_err,
    output logic                       rsp_timeout,

    output logic                       CYC,
    output logic                       STB,
    output logic                       WE,
    output logic [WB_ADDR_WIDTH-1:0]   ADR,
    output logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic                       ACK,
    input  logic                       ERR,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_R
);

    localparam int unsigned SelW = WB_DATA_WIDTH / 8;
    localparam int unsigned CmdW = cmd_width(WB_ADDR_WIDTH, WB_DATA_WIDTH);
    // Counter value at the start of the last permitted BUS cycle.
    localparam logic [TMO_CNT_W-1:0] TmoLast = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CmdW-1:0]          fifo_wdata;
    logic [CmdW-1:0]          fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;

    logic                     head_we;
    logic [WB_ADDR_WIDTH-1:0] head_adr;
    logic [WB_DATA_WIDTH-1:0] head_dat;
    logic [SelW-1:0]          head_sel;

    state_e                   state_q, state_d;
    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_w_q, dat_w_d;
    logic [SelW-1:0]          sel_q, sel_d;
    logic [TMO_CNT_W-1:0]     cnt_q, cnt_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     rsp_timeout_q, rsp_timeout_d;
    logic [WB_DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;

    logic                     ack_hit;
    logic                     err_hit;

    assign fifo_wdata = {cmd_we, cmd_adr, cmd_dat, cmd_sel};
    assign {head_we, head_adr, head_dat, head_sel} = fifo_rdata;

    wb_cmd_fifo #(
        .WIDTH (CmdW),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Only a definite 1 terminates; X/Z on the slave lines is not a termination.
    assign ack_hit = (ACK === 1'b1);
    assign err_hit = (ERR === 1'b1);

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        we_d          = we_q;
        adr_d         = adr_q;
        dat_w_d       = dat_w_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_dat_d     = rsp_dat_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    we_d     = head_we;
                    adr_d    = head_adr;
                    dat_w_d  = head_dat;
                    sel_d    = head_sel;
                    cyc_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = BUS;
                end
            end
            BUS: begin
                // Slave termination beats a coincident timeout; ERR beats ACK.
                if (ack_hit || err_hit) begin
                    cyc_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = err_hit;
                    rsp_timeout_d = 1'b0;
                    rsp_dat_d     = (!we_q && !err_hit) ? DAT_R : '0;
                    state_d       = RSP;
                end else if (cnt_q == TmoLast) begin
                    cyc_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_dat_d     = '0;
                    state_d       = RSP;
                end else begin
                    cnt_d = cnt_q + TMO_CNT_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_dat_d     = '0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            dat_w_q       <= '0;
            sel_q         <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_dat_q     <= '0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            dat_w_q       <= dat_w_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_dat_q     <= rsp_dat_d;
        end
    end

    assign cmd_ready   = !fifo_full;
    assign CYC         = cyc_q;
    assign STB         = cyc_q;
    assign WE          = we_q;
    assign ADR         = adr_q;
    assign DAT_W       = dat_w_q;
    assign SEL         = sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_dat     = rsp_dat_q;

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: read, write, FIFO full, ERR, timeout, reset abort.
module tb_wb_master_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        CYC, STB, WE;
    logic [31:0] ADR, DAT_W;
    logic [3:0]  SEL;
    logic        ACK = 1'b0;
    logic        ERR = 1'b0;
    logic [31:0] DAT_R = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_master_engine #(
        .WB_ADDR_WIDTH  (32),
        .WB_DATA_WIDTH  (32),
        .CMD_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .CYC         (CYC),
        .STB         (STB),
        .WE          (WE),
        .ADR         (ADR),
        .DAT_W       (DAT_W),
        .SEL         (SEL),
        .ACK         (ACK),
        .ERR         (ERR),
        .DAT_R       (DAT_R)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = 4'hF;
    endtask

    task automatic serve(input logic [31:0] exp_adr);
        for (int i = 0; i < 20 && CYC !== 1'b1; i++) tick();
        chk("serve_cyc", 64'(CYC), 64'd1);
        chk("serve_adr", 64'(ADR), 64'(exp_adr));
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("serve_rspv", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("serve_done", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_cyc", 64'(CYC), 64'd0);
        chk("rst_stb", 64'(STB), 64'd0);
        chk("rst_rdy", 64'(cmd_ready), 64'd1);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_adr", 64'(ADR), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single read, slave acks in the third CYC cycle.
        push_cmd(1'b0, 32'h100, 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("rd_cyc_push_edge", 64'(CYC), 64'd0);
        tick();
        chk("rd_cyc1", 64'(CYC), 64'd1);
        chk("rd_stb", 64'(STB), 64'd1);
        chk("rd_we", 64'(WE), 64'd0);
        chk("rd_adr", 64'(ADR), 64'h100);
        tick();
        chk("rd_cyc2", 64'(CYC), 64'd1);
        tick();
        chk("rd_cyc3", 64'(CYC), 64'd1);
        ACK = 1'b1;
        DAT_R = 32'hCAFEF00D;
        tick();
        ACK = 1'b0;
        DAT_R = '0;
        chk("rd_cyc_drop", 64'(CYC), 64'd0);
        chk("rd_rspv", 64'(rsp_valid), 64'd1);
        chk("rd_dat", 64'(rsp_dat), 64'hCAFEF00D);
        chk("rd_err", 64'(rsp_err), 64'd0);
        ERR = 1'b1;
        tick();
        ERR = 1'b0;
        chk("rd_hold_v", 64'(rsp_valid), 64'd1);
        chk("rd_hold_err", 64'(rsp_err), 64'd0);
        chk("rd_hold_dat", 64'(rsp_dat), 64'hCAFEF00D);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_done", 64'(rsp_valid), 64'd0);

        // Write: bus fields stable until ACK, response data zero.
        push_cmd(1'b1, 32'h40, 32'h12345678);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("wr_cyc", 64'(CYC), 64'd1);
        chk("wr_we", 64'(WE), 64'd1);
        chk("wr_adr", 64'(ADR), 64'h40);
        chk("wr_dat", 64'(DAT_W), 64'h12345678);
        chk("wr_sel", 64'(SEL), 64'hF);
        tick();
        chk("wr_hold_adr", 64'(ADR), 64'h40);
        chk("wr_hold_dat", 64'(DAT_W), 64'h12345678);
        chk("wr_hold_we", 64'(WE), 64'd1);
        ACK = 1'b1;
        DAT_R = 32'hDEADBEEF;
        tick();
        ACK = 1'b0;
        DAT_R = '0;
        chk("wr_rspv", 64'(rsp_valid), 64'd1);
        chk("wr_rsp_dat", 64'(rsp_dat), 64'd0);
        chk("wr_err", 64'(rsp_err), 64'd0);
        chk("wr_cyc_drop", 64'(CYC), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // FIFO full: one response parked, four queued, fifth held off.
        push_cmd(1'b0, 32'h200, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("ff_rspv", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, 32'h10 + 32'(4 * i), 32'h0);
            chk("ff_rdy_open", 64'(cmd_ready), 64'd1);
            tick();
        end
        chk("ff_full", 64'(cmd_ready), 64'd0);
        push_cmd(1'b0, 32'h20, 32'h0);
        tick();
        chk("ff_blocked", 64'(cmd_ready), 64'd0);
        chk("ff_rsp_hold", 64'(rsp_valid), 64'd1);
        chk("ff_no_cyc", 64'(CYC), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ff_consumed", 64'(rsp_valid), 64'd0);
        chk("ff_still_full", 64'(cmd_ready), 64'd0);
        tick();
        chk("ff_pop_cyc", 64'(CYC), 64'd1);
        chk("ff_reopen", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("ff_fifth_in", 64'(cmd_ready), 64'd0);
        serve(32'h10);
        serve(32'h14);
        serve(32'h18);
        serve(32'h1C);
        serve(32'h20);

        // ACK and ERR together: ERR wins, data zero.
        push_cmd(1'b0, 32'h300, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("err_cyc", 64'(CYC), 64'd1);
        ACK = 1'b1;
        ERR = 1'b1;
        DAT_R = 32'h55;
        tick();
        ACK = 1'b0;
        ERR = 1'b0;
        DAT_R = '0;
        chk("err_rspv", 64'(rsp_valid), 64'd1);
        chk("err_flag", 64'(rsp_err), 64'd1);
        chk("err_dat", 64'(rsp_dat), 64'd0);
        chk("err_tmo", 64'(rsp_timeout), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Timeout after exactly 8 BUS cycles.
        push_cmd(1'b0, 32'h400, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("tmo_cyc1", 64'(CYC), 64'd1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("tmo_cyc_hold", 64'(CYC), 64'd1);
        end
        tick();
        chk("tmo_cyc_drop", 64'(CYC), 64'd0);
        chk("tmo_rspv", 64'(rsp_valid), 64'd1);
        chk("tmo_flag", 64'(rsp_timeout), 64'd1);
        chk("tmo_err", 64'(rsp_err), 64'd0);
        chk("tmo_dat", 64'(rsp_dat), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ERR on the timeout edge beats the timeout.
        push_cmd(1'b0, 32'h500, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 2; i <= 8; i++) tick();
        chk("race_cyc", 64'(CYC), 64'd1);
        ERR = 1'b1;
        tick();
        ERR = 1'b0;
        chk("race_rspv", 64'(rsp_valid), 64'd1);
        chk("race_err", 64'(rsp_err), 64'd1);
        chk("race_tmo", 64'(rsp_timeout), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset mid-BUS with two commands queued.
        push_cmd(1'b0, 32'h600, 32'h0);
        tick();
        cmd_adr = 32'h604;
        tick();
        cmd_adr = 32'h608;
        tick();
        cmd_valid = 1'b0;
        chk("rm_cyc", 64'(CYC), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rm_cyc_async", 64'(CYC), 64'd0);
        chk("rm_stb_async", 64'(STB), 64'd0);
        chk("rm_rdy", 64'(cmd_ready), 64'd1);
        chk("rm_rspv", 64'(rsp_valid), 64'd0);
        ACK = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ACK = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rm_idle_cyc", 64'(CYC), 64'd0);
            chk("rm_no_rsp", 64'(rsp_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
